// File: rtl/pc_unit_pipelined.sv
// Next-PC selection and PC register for the MIPS fetch stage.
// A redirect that arrives while fetch cannot advance is held until it can.
//
// state | meaning
// IDLE  | first cycle after reset, no fetch issued yet
// RUN   | fetching, PC follows the computed target on every advance
// HOLD  | fetching, a captured redirect waits for the next advance
module pc_unit_pipelined #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] EXC_VEC   = 32'h0000_0800
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic [25:0]     instr_idx,
    input  logic [XLEN-1:0] br_offset,
    input  logic            branch,
    input  logic            equal,
    input  logic            bneorbeq,
    input  logic            jump,
    input  logic            isjr,
    input  logic [XLEN-1:0] jr_target,
    input  logic            iseret,
    input  logic [XLEN-1:0] epc,
    input  logic            hasexp,
    output logic [XLEN-1:0] pc,
    output logic            fetch_req,
    output logic            redirect_pending,
    output logic            misalign_exc,
    output logic [XLEN-1:0] badaddr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pend_target;

    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] br_t;
    logic [XLEN-1:0] j_t;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fault;
    logic            taken;
    logic            redirect;
    logic            misaligned;
    logic            advance;

    assign advance = fetch_req & fetch_ready & ~stall;

    always_comb begin
        pc4        = pc + XLEN'(4);
        taken      = branch & (equal ^ bneorbeq);
        br_t       = pc4 + (br_offset << 2);
        j_t        = {pc4[XLEN-1:28], instr_idx, 2'b00};
        target     = pc4;
        redirect   = 1'b0;
        misaligned = 1'b0;
        fault      = epc;
        if (hasexp) begin
            target   = EXC_VEC;
            redirect = 1'b1;
        end else if (iseret) begin
            redirect = 1'b1;
            fault    = epc;
            if (epc[1:0] != 2'b00) begin
                target     = EXC_VEC;
                misaligned = 1'b1;
            end else begin
                target = epc;
            end
        end else if (isjr) begin
            redirect = 1'b1;
            fault    = jr_target;
            if (jr_target[1:0] != 2'b00) begin
                target     = EXC_VEC;
                misaligned = 1'b1;
            end else begin
                target = jr_target;
            end
        end else if (jump) begin
            target   = j_t;
            redirect = 1'b1;
        end else if (taken) begin
            target   = br_t;
            redirect = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            pc               <= RESET_VEC;
            pend_target      <= RESET_VEC;
            fetch_req        <= 1'b0;
            redirect_pending <= 1'b0;
            misalign_exc     <= 1'b0;
            badaddr          <= '0;
        end else begin
            misalign_exc <= 1'b0;
            case (state)
                IDLE: begin
                    state     <= RUN;
                    fetch_req <= 1'b1;
                end
                RUN: begin
                    if (advance) begin
                        pc <= target;
                        if (misaligned) begin
                            misalign_exc <= 1'b1;
                            badaddr      <= fault;
                        end
                    end else if (redirect) begin
                        pend_target      <= target;
                        redirect_pending <= 1'b1;
                        state            <= HOLD;
                        if (misaligned) begin
                            misalign_exc <= 1'b1;
                            badaddr      <= fault;
                        end
                    end
                end
                HOLD: begin
                    if (advance) begin
                        pc               <= pend_target;
                        redirect_pending <= 1'b0;
                        state            <= RUN;
                    end else if (hasexp) begin
                        // an exception outranks whatever redirect was captured first
                        pend_target <= EXC_VEC;
                    end
                end
                default: begin
                    state            <= IDLE;
                    fetch_req        <= 1'b0;
                    redirect_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit_pipelined.sv
// Self-checking bench for pc_unit_pipelined: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_pc_unit_pipelined;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_0800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_ready;
    logic        stall;
    logic [25:0] instr_idx;
    logic [31:0] br_offset;
    logic        branch;
    logic        equal;
    logic        bneorbeq;
    logic        jump;
    logic        isjr;
    logic [31:0] jr_target;
    logic        iseret;
    logic [31:0] epc;
    logic        hasexp;
    logic [31:0] pc;
    logic        fetch_req;
    logic        redirect_pending;
    logic        misalign_exc;
    logic [31:0] badaddr;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_freq;
    logic        m_pend_v;
    logic [31:0] m_pend_t;
    logic        m_mis;
    logic [31:0] m_bad;

    pc_unit_pipelined #(
        .XLEN(32), .RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .stall(stall),
        .instr_idx(instr_idx), .br_offset(br_offset), .branch(branch),
        .equal(equal), .bneorbeq(bneorbeq), .jump(jump), .isjr(isjr),
        .jr_target(jr_target), .iseret(iseret), .epc(epc), .hasexp(hasexp),
        .pc(pc), .fetch_req(fetch_req), .redirect_pending(redirect_pending),
        .misalign_exc(misalign_exc), .badaddr(badaddr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc     = RESET_VEC;
        m_freq   = 1'b0;
        m_pend_v = 1'b0;
        m_pend_t = 32'h0;
        m_mis    = 1'b0;
        m_bad    = 32'h0;
    endtask

    // One clock of the architectural behaviour, evaluated from current inputs.
    task automatic model_step();
        logic [31:0] nxt;
        logic [31:0] dest;
        logic [31:0] bad;
        logic        redir;
        logic        trap;
        logic        go;
        logic        pulse;
        nxt   = m_pc + 32'd4;
        dest  = nxt;
        bad   = 32'h0;
        redir = 1'b1;
        trap  = 1'b0;
        pulse = 1'b0;
        go    = m_freq && fetch_ready && !stall;
        if (hasexp) dest = EXC_VEC;
        else if (iseret) begin
            if (epc % 4 != 0) begin dest = EXC_VEC; trap = 1'b1; bad = epc; end
            else dest = epc;
        end else if (isjr) begin
            if (jr_target % 4 != 0) begin dest = EXC_VEC; trap = 1'b1; bad = jr_target; end
            else dest = jr_target;
        end else if (jump) dest = (nxt & 32'hF000_0000) | (32'(instr_idx) * 4);
        else if (branch && (equal != bneorbeq)) dest = nxt + br_offset * 4;
        else redir = 1'b0;

        if (!m_freq) m_freq = 1'b1;
        else if (go) begin
            if (m_pend_v) m_pc = m_pend_t;
            else begin
                m_pc = dest;
                if (trap) begin pulse = 1'b1; m_bad = bad; end
            end
            m_pend_v = 1'b0;
        end else if (redir) begin
            if (!m_pend_v) begin
                m_pend_v = 1'b1;
                m_pend_t = dest;
                if (trap) begin pulse = 1'b1; m_bad = bad; end
            end else if (hasexp) m_pend_t = EXC_VEC;
        end
        m_mis = pulse;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        fetch_ready = 1'b1; stall = 1'b0; instr_idx = '0; br_offset = '0;
        branch = 1'b0; equal = 1'b0; bneorbeq = 1'b0; jump = 1'b0;
        isjr = 1'b0; jr_target = '0; iseret = 1'b0; epc = '0; hasexp = 1'b0;
    endtask

    task automatic apply_reset();
        clear_ctrl();
        rst_n = 1'b0;
        model_reset();
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_pc(input logic [31:0] a);
        clear_ctrl();
        isjr = 1'b1; jr_target = a;
        tick();
        clear_ctrl();
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [4];
        exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC};
        apply_reset();
        checks++; if (pc !== RESET_VEC) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, RESET_VEC); end
        checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL reset_freq got %b exp 0", fetch_req); end
        checks++; if (redirect_pending !== 1'b0 || misalign_exc !== 1'b0 || badaddr !== 32'h0)
            begin errors++; $display("FAIL reset_flags got %b %b %h exp 0 0 0", redirect_pending, misalign_exc, badaddr); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (pc !== exp_seq[i] || fetch_req !== 1'b1)
                begin errors++; $display("FAIL seq_%0d got pc %h freq %b exp %h 1", i, pc, fetch_req, exp_seq[i]); end
        end
    endtask

    task automatic test_branch();
        set_pc(32'h100);
        branch = 1'b1; equal = 1'b1; bneorbeq = 1'b0; br_offset = 32'hFFFF_FFFE;
        tick();
        checks++; if (pc !== 32'h0000_00FC) begin errors++; $display("FAIL beq_taken got %h exp 000000fc", pc); end
        set_pc(32'h100);
        branch = 1'b1; equal = 1'b1; bneorbeq = 1'b1; br_offset = 32'hFFFF_FFFE;
        tick();
        checks++; if (pc !== 32'h0000_0104) begin errors++; $display("FAIL bne_not_taken got %h exp 00000104", pc); end
    endtask

    task automatic test_jump();
        set_pc(32'h0040_0010);
        jump = 1'b1; instr_idx = 26'h010_0000;
        tick();
        checks++; if (pc !== 32'h0040_0000) begin errors++; $display("FAIL jump got %h exp 00400000", pc); end
        jump = 1'b1; isjr = 1'b1; jr_target = 32'h2000;
        tick();
        checks++; if (pc !== 32'h0000_2000) begin errors++; $display("FAIL jr_over_jump got %h exp 00002000", pc); end
    endtask

    task automatic test_stall_capture();
        logic [31:0] held;
        clear_ctrl();
        held = pc;
        stall = 1'b1; isjr = 1'b1; jr_target = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (redirect_pending !== 1'b1 || pc !== held)
                begin errors++; $display("FAIL stall_hold_%0d got pend %b pc %h exp 1 %h", i, redirect_pending, pc, held); end
        end
        isjr = 1'b0;
        tick();
        checks++; if (pc !== held || fetch_req !== 1'b1)
            begin errors++; $display("FAIL stall_no_redirect got pc %h freq %b exp %h 1", pc, fetch_req, held); end
        stall = 1'b0;
        tick();
        checks++; if (pc !== 32'h3000 || redirect_pending !== 1'b0)
            begin errors++; $display("FAIL stall_release got pc %h pend %b exp 00003000 0", pc, redirect_pending); end
    endtask

    task automatic test_hasexp_override();
        clear_ctrl();
        stall = 1'b1; isjr = 1'b1; jr_target = 32'h3000;
        tick();
        isjr = 1'b0; jump = 1'b1; instr_idx = 26'h123;
        tick();
        jump = 1'b0; hasexp = 1'b1;
        tick();
        hasexp = 1'b0;
        tick();
        stall = 1'b0;
        tick();
        checks++; if (pc !== EXC_VEC || misalign_exc !== 1'b0)
            begin errors++; $display("FAIL hasexp_override got pc %h mis %b exp %h 0", pc, misalign_exc, EXC_VEC); end
    endtask

    task automatic test_misalign();
        clear_ctrl();
        iseret = 1'b1; epc = 32'h0000_1002;
        tick();
        checks++; if (pc !== EXC_VEC || misalign_exc !== 1'b1 || badaddr !== 32'h1002)
            begin errors++; $display("FAIL eret_misalign got pc %h mis %b bad %h exp 00000800 1 00001002", pc, misalign_exc, badaddr); end
        clear_ctrl();
        tick();
        checks++; if (misalign_exc !== 1'b0 || pc !== 32'h804)
            begin errors++; $display("FAIL misalign_pulse got mis %b pc %h exp 0 00000804", misalign_exc, pc); end
        hasexp = 1'b1; iseret = 1'b1; epc = 32'h0000_2003;
        tick();
        checks++; if (misalign_exc !== 1'b0 || badaddr !== 32'h1002)
            begin errors++; $display("FAIL hasexp_no_trap got mis %b bad %h exp 0 00001002", misalign_exc, badaddr); end
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap got %h exp 00000000", pc); end
    endtask

    task automatic test_reset_mid_hold();
        clear_ctrl();
        stall = 1'b1; isjr = 1'b1; jr_target = 32'h3000;
        tick();
        rst_n = 1'b0;
        model_reset();
        #2;
        checks++; if (pc !== RESET_VEC || redirect_pending !== 1'b0 || fetch_req !== 1'b0)
            begin errors++; $display("FAIL reset_mid_hold got pc %h pend %b freq %b exp %h 0 0", pc, redirect_pending, fetch_req, RESET_VEC); end
        clear_ctrl();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL after_reset_hold got %h exp 00000004", pc); end
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
        return r;
    endfunction

    task automatic test_random();
        logic [31:0] off;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            fetch_ready = ($urandom_range(0, 3) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            hasexp      = ($urandom_range(0, 19) == 0);
            iseret      = ($urandom_range(0, 11) == 0);
            isjr        = ($urandom_range(0, 9) == 0);
            jump        = ($urandom_range(0, 7) == 0);
            branch      = ($urandom_range(0, 3) == 0);
            equal       = 1'($urandom_range(0, 1));
            bneorbeq    = 1'($urandom_range(0, 1));
            instr_idx   = 26'($urandom);
            off         = 32'($urandom_range(0, 65535));
            br_offset   = {{16{off[15]}}, off[15:0]};
            jr_target   = rand_target();
            epc         = rand_target();
            tick();
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc_%0d got %h exp %h", i, pc, m_pc); end
            checks++; if (fetch_req !== m_freq) begin errors++; $display("FAIL rnd_freq_%0d got %b exp %b", i, fetch_req, m_freq); end
            checks++; if (redirect_pending !== m_pend_v) begin errors++; $display("FAIL rnd_pend_%0d got %b exp %b", i, redirect_pending, m_pend_v); end
            checks++; if (misalign_exc !== m_mis) begin errors++; $display("FAIL rnd_mis_%0d got %b exp %b", i, misalign_exc, m_mis); end
            checks++; if (badaddr !== m_bad) begin errors++; $display("FAIL rnd_bad_%0d got %h exp %h", i, badaddr, m_bad); end
        end
    endtask

    initial begin
        clear_ctrl();
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_branch();
        test_jump();
        test_stall_capture();
        test_hasexp_override();
        test_misalign();
        test_wrap();
        test_reset_mid_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
